uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame (legal range 1..16).

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port tick, input, 1 bit: one-clk baud strobe; each tick ends one bit period.
REQ-005 The block SHALL have port data_valid, input, 1 bit: a frame request, sampled only in IDLE.
REQ-006 The block SHALL have port parity_en, input, 1 bit: selects a parity bit for the frame, sampled on accept.
REQ-007 The block SHALL have port ser_load, output, 1 bit: strobe telling the serializer to capture the input word.
REQ-008 The block SHALL have port ser_shift, output, 1 bit: strobe telling the serializer to advance to its next data bit.
REQ-009 The block SHALL have port mux_sel, output, 2 bits: line source; 00 start(0), 01 stop/idle(1), 10 serial data, 11 parity bit.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-clk pulse at the end of a frame.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, START, DATA, PARITY and STOP, plus an internal bit_cnt and a registered par_en_q.
REQ-013 Accept SHALL occur when state is IDLE and data_valid=1, with or without tick.
REQ-014 On accept, ser_load SHALL be 1 combinationally in that same cycle, so the serializer and parity calculator capture the same word.
REQ-015 On accept, par_en_q SHALL capture parity_en and the next state SHALL be START.
REQ-016 busy SHALL be a decode of the registered state: 0 in IDLE and 1 in every other state, so it rises the cycle after accept.
REQ-017 A tick coinciding with accept SHALL be ignored, so START lasts until the next tick.
REQ-018 START on tick SHALL go to DATA with bit_cnt=0.
REQ-019 DATA on tick with bit_cnt<DATA_WIDTH-1 SHALL increment bit_cnt and assert ser_shift for that single cycle.
REQ-020 DATA on tick with bit_cnt=DATA_WIDTH-1 SHALL clear bit_cnt, SHALL NOT assert ser_shift, and SHALL go to PARITY if par_en_q=1, else to STOP.
REQ-021 PARITY on tick SHALL go to STOP.
REQ-022 STOP on tick SHALL go to IDLE and assert frame_done for that single cycle.
REQ-023 No direct STOP->START transition SHALL exist; the minimum inter-frame gap is one clk in IDLE with the line high.
REQ-024 mux_sel SHALL be a pure decode of state: IDLE 01, START 00, DATA 10, PARITY 11, STOP 01.
REQ-025 Without a tick, every non-IDLE state SHALL hold indefinitely.
REQ-026 ser_shift and frame_done SHALL be 0 whenever tick=0.
REQ-027 A parity_en change after accept SHALL NOT affect the current frame.
REQ-028 data_valid SHALL be ignored while busy=1; no queuing.
REQ-029 Frame length SHALL be 1+DATA_WIDTH+par_en_q+1 ticks, counted from the first tick after accept.

Reset
REQ-030 While rst=0, the block SHALL force state=IDLE, bit_cnt=0 and par_en_q=0.
REQ-031 While rst=0, outputs SHALL be ser_load=0, ser_shift=0, mux_sel=01, busy=0 and frame_done=0, holding the line high.
REQ-032 Reset asserted mid-frame SHALL abort immediately with no frame_done pulse.
REQ-033 After reset release the block SHALL be ready to accept on the first edge.

Verification
REQ-034 The bench SHALL cover a parity frame: DATA_WIDTH=8, tick every 4 clk, parity_en=1, data_valid for 1 clk -> ser_load once, mux_sel 00,10x8,11,01 over 11 ticks, 7 ser_shift pulses, frame_done once, busy high for 44 clk +/- tick phase.
REQ-035 The bench SHALL cover a no-parity frame: parity_en=0 -> PARITY skipped, mux_sel never 11, 10 ticks per frame.
REQ-036 The bench SHALL cover back-to-back requests: data_valid held high continuously -> a second ser_load exactly 1 clk after frame_done, and no ser_load while busy=1.
REQ-037 The bench SHALL cover tick coincident with accept: START spans the next full tick interval, and mux_sel=00 for 4 clk at a 4-clk tick period.
REQ-038 The bench SHALL cover reset mid-DATA: rst=0 at bit_cnt=3 -> same-instant mux_sel=01, busy=0, no frame_done; a new frame after release runs complete and correct.
REQ-039 The bench SHALL cover parity_en toggling mid-frame: the frame shape follows the value captured at accept.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   Frame sequencer for a UART transmitter. It steers an external serializer
//   and a line multiplexer through start, data, optional parity and stop bit
//   periods. One bit period ends on each baud tick.
//
// Parameters
//   DATA_WIDTH  data bits per frame (1..16)
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   tick        one-clk baud strobe, ends the current bit period
//   data_valid  frame request, honoured only while idle
//   parity_en   adds a parity bit to the frame, captured on accept
//   ser_load    serializer capture strobe (asserted in the accept cycle)
//   ser_shift   serializer advance strobe (one per data bit boundary)
//   mux_sel     line source: 00 start, 01 stop/idle, 10 data, 11 parity
//   busy        frame in progress
//   frame_done  one-clk pulse on the tick that ends the stop bit
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       data_valid,
  input  logic       parity_en,
  output logic       ser_load,
  output logic       ser_shift,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_en_q;

  logic accept;
  logic last_bit;

  assign accept   = (state == IDLE) && data_valid;
  assign last_bit = (bit_cnt == LAST_BIT);

  // A tick in the accept cycle is deliberately not looked at: START always
  // spans one complete bit period after the request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            par_en_q <= parity_en;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (last_bit) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (tick) state <= STOP;
        end
        STOP: begin
          // Always returns through IDLE, guaranteeing one idle-high clk
          // between frames.
          if (tick) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  // Strobes are combinational so they line up with the cycle in which the
  // serializer must act: ser_load with the request itself, ser_shift and
  // frame_done with the tick. The reset term keeps ser_load low while rst is
  // asserted even if data_valid is high.
  always_comb begin
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    frame_done = 1'b0;
    mux_sel    = 2'b01;
    busy       = 1'b0;

    ser_load   = rst && accept;
    ser_shift  = (state == DATA) && tick && !last_bit;
    frame_done = (state == STOP) && tick;
    busy       = (state != IDLE);

    case (state)
      START:   mux_sel = 2'b00;
      DATA:    mux_sel = 2'b10;
      PARITY:  mux_sel = 2'b11;
      default: mux_sel = 2'b01;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       data_valid;
  logic       parity_en;
  logic       ser_load;
  logic       ser_shift;
  logic [1:0] mux_sel;
  logic       busy;
  logic       frame_done;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .tick       (tick),
    .data_valid (data_valid),
    .parity_en  (parity_en),
    .ser_load   (ser_load),
    .ser_shift  (ser_shift),
    .mux_sel    (mux_sel),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Scoreboard: one expected line source per bit period, pushed when a frame
  // is requested and popped at each tick that ends a busy bit period.
  logic [1:0] sb_q[$];

  task automatic push_frame(input bit par);
    sb_q.push_back(2'b00);
    for (int i = 0; i < W; i++) sb_q.push_back(2'b10);
    if (par) sb_q.push_back(2'b11);
    sb_q.push_back(2'b01);
  endtask

  // Per-frame activity counters maintained by the monitor.
  int loads, shifts, dones, pops, busy_cyc, start_cyc, par_cyc;
  int load_while_busy, strobe_no_tick, idle_line_err, gap;
  int cnum = 0;
  int done_at = 0;

  task automatic clr();
    loads = 0; shifts = 0; dones = 0; pops = 0; busy_cyc = 0;
    start_cyc = 0; par_cyc = 0; load_while_busy = 0; strobe_no_tick = 0;
    idle_line_err = 0; gap = -1;
  endtask

  always @(negedge clk) begin
    #2;
    cnum++;
    if (ser_load) begin
      loads++;
      if (busy) load_while_busy++;
      if (dones > 0) gap = cnum - done_at;
    end
    if (ser_shift) shifts++;
    if ((ser_shift || frame_done) && !tick) strobe_no_tick++;
    if (frame_done) begin
      dones++;
      done_at = cnum;
    end
    if (busy) busy_cyc++;
    if (busy && mux_sel == 2'b00) start_cyc++;
    if (mux_sel == 2'b11) par_cyc++;
    if (!busy && mux_sel != 2'b01) idle_line_err++;
    if (busy && tick) begin
      pops++;
      if (sb_q.size() == 0) check("sb_underflow", 1, 0);
      else check("mux_sel_at_tick", int'(mux_sel), int'(sb_q.pop_front()));
    end
  end

  // Tick generator lives in the driver: one tick every 4 clk at phase 3.
  int ph = 0;

  task automatic cyc();
    @(negedge clk);
    ph = (ph + 1) % 4;
    tick = (ph == 3);
  endtask

  task automatic wait_dones(input int want, input int budget);
    for (int n = 0; n < budget && dones < want; n++) cyc();
    check("frame_done_timeout", (dones >= want) ? 1 : 0, 1);
  endtask

  typedef struct {
    bit par;       // parity_en at accept
    bit tog;       // flip parity_en right after accept
    bit coin;      // accept coincides with a tick
    int n_ticks;
    int busy_cyc;
    int start_cyc;
    int par_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{par: 1, tog: 0, coin: 0, n_ticks: 11, busy_cyc: 43, start_cyc: 3, par_cyc: 4};
    vecs[1] = '{par: 0, tog: 0, coin: 0, n_ticks: 10, busy_cyc: 39, start_cyc: 3, par_cyc: 0};
    vecs[2] = '{par: 1, tog: 0, coin: 1, n_ticks: 11, busy_cyc: 44, start_cyc: 4, par_cyc: 4};
    vecs[3] = '{par: 1, tog: 1, coin: 0, n_ticks: 11, busy_cyc: 43, start_cyc: 3, par_cyc: 4};
    vecs[4] = '{par: 0, tog: 1, coin: 0, n_ticks: 10, busy_cyc: 39, start_cyc: 3, par_cyc: 0};
    vecs[5] = '{par: 0, tog: 0, coin: 1, n_ticks: 10, busy_cyc: 40, start_cyc: 4, par_cyc: 0};

    clr();
    rst_n = 1'b0;
    tick = 1'b0;
    data_valid = 1'b1;   // must not produce ser_load while in reset
    parity_en = 1'b0;
    repeat (3) cyc();
    #1;
    check("rst_ser_load", int'(ser_load), 0);
    check("rst_ser_shift", int'(ser_shift), 0);
    check("rst_mux_sel", int'(mux_sel), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    cyc();
    data_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) cyc();

    // Table-driven single frames.
    for (int v = 0; v < 6; v++) begin
      while (ph != (vecs[v].coin ? 2 : 3)) cyc();
      cyc();
      clr();
      data_valid = 1'b1;
      parity_en = vecs[v].par;
      push_frame(vecs[v].par);
      cyc();
      data_valid = 1'b0;
      if (vecs[v].tog) parity_en = ~vecs[v].par;
      wait_dones(1, 200);
      repeat (6) cyc();
      check("loads", loads, 1);
      check("shifts", shifts, W - 1);
      check("dones", dones, 1);
      check("ticks", pops, vecs[v].n_ticks);
      check("busy_cycles", busy_cyc, vecs[v].busy_cyc);
      check("start_cycles", start_cyc, vecs[v].start_cyc);
      check("parity_cycles", par_cyc, vecs[v].par_cyc);
      check("strobe_without_tick", strobe_no_tick, 0);
      check("idle_line_not_high", idle_line_err, 0);
      check("sb_leftover", sb_q.size(), 0);
      sb_q.delete();
    end

    // Back-to-back: data_valid held high across two frames.
    while (ph != 3) cyc();
    cyc();
    clr();
    data_valid = 1'b1;
    parity_en = 1'b0;
    push_frame(1'b0);
    push_frame(1'b0);
    wait_dones(2, 300);
    data_valid = 1'b0;
    repeat (6) cyc();
    check("b2b_loads", loads, 2);
    check("b2b_dones", dones, 2);
    check("b2b_load_gap", gap, 1);
    check("b2b_load_while_busy", load_while_busy, 0);
    check("b2b_shifts", shifts, 2 * (W - 1));
    check("b2b_ticks", pops, 20);
    check("b2b_sb_leftover", sb_q.size(), 0);
    sb_q.delete();

    // Reset during DATA with bit_cnt at 3, then an immediate new request.
    while (ph != 3) cyc();
    cyc();
    clr();
    data_valid = 1'b1;
    parity_en = 1'b1;
    push_frame(1'b1);
    cyc();
    data_valid = 1'b0;
    begin
      int nt = 0;
      for (int n = 0; n < 40 && nt < 4; n++) begin
        cyc();
        if (tick) nt++;
      end
      check("reach_bit3_timeout", nt, 4);
    end
    cyc();
    #1;
    check("pre_rst_mux_data", int'(mux_sel), 2);
    rst_n = 1'b0;
    #1;
    check("abort_mux_sel", int'(mux_sel), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_frame_done", int'(frame_done), 0);
    check("abort_ser_shift", int'(ser_shift), 0);
    sb_q.delete();
    repeat (3) cyc();
    #3;
    check("abort_no_done", dones, 0);
    cyc();
    clr();
    rst_n = 1'b1;
    data_valid = 1'b1;
    parity_en = 1'b0;
    push_frame(1'b0);
    #1;
    check("first_edge_ser_load", int'(ser_load), 1);
    cyc();
    data_valid = 1'b0;
    wait_dones(1, 200);
    repeat (6) cyc();
    check("post_rst_loads", loads, 1);
    check("post_rst_shifts", shifts, W - 1);
    check("post_rst_dones", dones, 1);
    check("post_rst_ticks", pops, 10);
    check("post_rst_par_cycles", par_cyc, 0);
    check("post_rst_sb_leftover", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
